// File: rtl/game_level_sequencer.sv
// Game-flow controller: start screen, NUM_LEVELS levels with transitions, victory and death screens.
// Optional GAME_SEQ_PAUSE_EN adds a playerPause input and a PAUSED state.
module game_level_sequencer #(
  parameter int unsigned NUM_LEVELS       = 4,
  parameter int unsigned COLL_W           = 3,
  parameter int unsigned ENEMIES_BASE     = 2,
  parameter int unsigned SPEED_BASE       = 120,
  parameter int unsigned SPEED_STEP       = 60,
  parameter int unsigned TREE_BASE        = 8,
  parameter int unsigned TRANSITION_TICKS = 120
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [2:0]        currLife,
  input  logic [COLL_W-1:0] shotEnemyCollision,
  input  logic              slowClk,
  input  logic              playerTrigger,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic              playerPause,
`endif
  output logic              pause,
  output logic              start_screen,
  output logic              death_screen,
  output logic              victory_screen,
  output logic [3:0]        tree_count,
  output logic [10:0]       curEnemySpeed,
  output logic [2:0]        level,
  output logic [3:0]        enemies_left,
  output logic [2:0]        currentGameState,
  output logic              newLevel,
  output logic              requestTime,
  output logic [10:0]       slowClkRequest
);

  localparam int unsigned SPEED_MAX = 2047;
  localparam int unsigned TREE_MAX  = 15;
  localparam int unsigned LEFT_MAX  = 15;

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_PLAY       = 3'd1,
    ST_LEVEL_DONE = 3'd2,
    ST_TRANSITION = 3'd3,
    ST_VICTORY    = 3'd4,
    ST_DEATH      = 3'd5
`ifdef GAME_SEQ_PAUSE_EN
    , ST_PAUSED   = 3'd6
`endif
  } state_e;

  function automatic logic [3:0] req_kills(input logic [2:0] lvl);
    int unsigned r;
    r = ENEMIES_BASE + 32'(lvl);
    if (r > COLL_W + ENEMIES_BASE) r = COLL_W + ENEMIES_BASE;
    if (r > LEFT_MAX) r = LEFT_MAX;
    return 4'(r);
  endfunction

  function automatic logic [10:0] speed_for(input logic [2:0] lvl);
    int unsigned s;
    s = SPEED_BASE + 32'(lvl) * SPEED_STEP;
    if (s > SPEED_MAX) s = SPEED_MAX;
    return 11'(s);
  endfunction

  function automatic logic [3:0] tree_for(input logic [2:0] lvl);
    int unsigned t;
    t = TREE_BASE + 32'(lvl);
    if (t > TREE_MAX) t = TREE_MAX;
    return 4'(t);
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          level_q, level_d;
  logic [3:0]          left_q, left_d;
  logic                trig_q;
  logic [COLL_W-1:0]   coll_q;
`ifdef GAME_SEQ_PAUSE_EN
  logic                ppause_q;
  logic                pause_rise;
`endif
  logic                trig_rise;
  logic [COLL_W-1:0]   hit_rise;
  int unsigned         kills;

  // Outputs are flopped from a decode of the next state, so they equal a Moore decode of state_q.
  logic        pause_q, pause_d;
  logic        start_q, start_d;
  logic        death_q, death_d;
  logic        victory_q, victory_d;
  logic [3:0]  tree_q, tree_d;
  logic [10:0] speed_q, speed_d;
  logic [2:0]  gstate_q, gstate_d;
  logic        new_level_q, new_level_d;
  logic        req_time_q, req_time_d;
  logic [10:0] slow_req_q, slow_req_d;

  always_comb begin
    trig_rise = playerTrigger & ~trig_q;
    hit_rise  = shotEnemyCollision & ~coll_q;
`ifdef GAME_SEQ_PAUSE_EN
    pause_rise = playerPause & ~ppause_q;
`endif
    kills = 0;
    for (int i = 0; i < int'(COLL_W); i++) kills = kills + 32'(hit_rise[i]);

    state_d = state_q;
    level_d = level_q;
    left_d  = left_q;
    case (state_q)
      ST_START: if (trig_rise) begin
        state_d = ST_PLAY;
        level_d = 3'd0;
        left_d  = req_kills(3'd0);
      end
      // Level clear wins over a simultaneous death.
      ST_PLAY: begin
        if (kills >= 32'(left_q)) begin
          state_d = ST_LEVEL_DONE;
          left_d  = 4'd0;
        end else begin
          left_d = left_q - 4'(kills);
          if (currLife == 3'd0) state_d = ST_DEATH;
`ifdef GAME_SEQ_PAUSE_EN
          else if (pause_rise) state_d = ST_PAUSED;
`endif
        end
      end
      ST_LEVEL_DONE: state_d = (32'(level_q) == NUM_LEVELS - 1) ? ST_VICTORY : ST_TRANSITION;
      ST_TRANSITION: if (slowClk) begin
        state_d = ST_PLAY;
        level_d = level_q + 3'd1;
        left_d  = req_kills(level_q + 3'd1);
      end
      ST_VICTORY: if (trig_rise) begin
        state_d = ST_PLAY;
        level_d = 3'd0;
        left_d  = req_kills(3'd0);
      end
      ST_DEATH: if (trig_rise) begin
        state_d = ST_START;
        level_d = 3'd0;
        left_d  = req_kills(3'd0);
      end
`ifdef GAME_SEQ_PAUSE_EN
      ST_PAUSED: if (pause_rise) state_d = ST_PLAY;
`endif
      default: begin
        state_d = ST_START;
        level_d = 3'd0;
        left_d  = req_kills(3'd0);
      end
    endcase

    pause_d     = 1'b1;
    start_d     = 1'b0;
    death_d     = 1'b0;
    victory_d   = 1'b0;
    new_level_d = 1'b0;
    req_time_d  = 1'b0;
    slow_req_d  = 11'd0;
    gstate_d    = 3'd0;
    case (state_d)
      ST_PLAY: begin
        pause_d  = 1'b0;
        gstate_d = 3'd1;
      end
      ST_LEVEL_DONE: begin
        req_time_d = 1'b1;
        slow_req_d = 11'(TRANSITION_TICKS);
        gstate_d   = 3'd2;
      end
      ST_TRANSITION: begin
        new_level_d = 1'b1;
        gstate_d    = 3'd2;
      end
      ST_VICTORY: begin
        victory_d = 1'b1;
        gstate_d  = 3'd4;
      end
      ST_DEATH: begin
        death_d  = 1'b1;
        gstate_d = 3'd5;
      end
`ifdef GAME_SEQ_PAUSE_EN
      ST_PAUSED: gstate_d = 3'd6;
`endif
      default: start_d = 1'b1;
    endcase
    tree_d  = tree_for(level_d);
    speed_d = speed_for(level_d);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_START;
      level_q     <= 3'd0;
      left_q      <= req_kills(3'd0);
      trig_q      <= 1'b0;
      coll_q      <= '0;
`ifdef GAME_SEQ_PAUSE_EN
      ppause_q    <= 1'b0;
`endif
      pause_q     <= 1'b1;
      start_q     <= 1'b1;
      death_q     <= 1'b0;
      victory_q   <= 1'b0;
      tree_q      <= tree_for(3'd0);
      speed_q     <= speed_for(3'd0);
      gstate_q    <= 3'd0;
      new_level_q <= 1'b0;
      req_time_q  <= 1'b0;
      slow_req_q  <= 11'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      left_q      <= left_d;
      trig_q      <= playerTrigger;
      coll_q      <= shotEnemyCollision;
`ifdef GAME_SEQ_PAUSE_EN
      ppause_q    <= playerPause;
`endif
      pause_q     <= pause_d;
      start_q     <= start_d;
      death_q     <= death_d;
      victory_q   <= victory_d;
      tree_q      <= tree_d;
      speed_q     <= speed_d;
      gstate_q    <= gstate_d;
      new_level_q <= new_level_d;
      req_time_q  <= req_time_d;
      slow_req_q  <= slow_req_d;
    end
  end

  assign pause            = pause_q;
  assign start_screen     = start_q;
  assign death_screen     = death_q;
  assign victory_screen   = victory_q;
  assign tree_count       = tree_q;
  assign curEnemySpeed    = speed_q;
  assign level            = level_q;
  assign enemies_left     = left_q;
  assign currentGameState = gstate_q;
  assign newLevel         = new_level_q;
  assign requestTime      = req_time_q;
  assign slowClkRequest   = slow_req_q;

endmodule

// File: tb/tb_game_level_sequencer.sv
// Table-driven bench for game_level_sequencer: per-cycle vectors plus an async-reset-in-transition sequence.
module tb_game_level_sequencer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [2:0]  currLife = 3'd3;
  logic [2:0]  shotEnemyCollision = 3'd0;
  logic        slowClk = 1'b0;
  logic        playerTrigger = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
  logic        playerPause = 1'b0;
`endif
  logic        pause, start_screen, death_screen, victory_screen;
  logic [3:0]  tree_count;
  logic [10:0] curEnemySpeed;
  logic [2:0]  level;
  logic [3:0]  enemies_left;
  logic [2:0]  currentGameState;
  logic        newLevel, requestTime;
  logic [10:0] slowClkRequest;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  game_level_sequencer dut (
    .clk(clk), .resetN(resetN), .currLife(currLife),
    .shotEnemyCollision(shotEnemyCollision), .slowClk(slowClk), .playerTrigger(playerTrigger),
`ifdef GAME_SEQ_PAUSE_EN
    .playerPause(playerPause),
`endif
    .pause(pause), .start_screen(start_screen), .death_screen(death_screen),
    .victory_screen(victory_screen), .tree_count(tree_count), .curEnemySpeed(curEnemySpeed),
    .level(level), .enemies_left(enemies_left), .currentGameState(currentGameState),
    .newLevel(newLevel), .requestTime(requestTime), .slowClkRequest(slowClkRequest)
  );

  // scr = {start, death, victory}; misc = {pause, newLevel, requestTime}
  typedef struct {
    logic       rst;
    logic [2:0] life;
    logic [2:0] coll;
    logic       sclk;
    logic       trig;
    logic [2:0] st;
    logic [2:0] lvl;
    logic [3:0] left;
    logic [2:0] scr;
    logic [2:0] misc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [2:0] life, input logic [2:0] coll,
                     input logic sclk, input logic trig, input logic [2:0] st,
                     input logic [2:0] lvl, input logic [3:0] left,
                     input logic [2:0] scr, input logic [2:0] misc);
    vec_t v;
    v.rst = rst; v.life = life; v.coll = coll; v.sclk = sclk; v.trig = trig;
    v.st = st; v.lvl = lvl; v.left = left; v.scr = scr; v.misc = misc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    check($sformatf("v%0d state", idx), 32'(currentGameState), 32'(v.st));
    check($sformatf("v%0d level", idx), 32'(level), 32'(v.lvl));
    check($sformatf("v%0d enemies_left", idx), 32'(enemies_left), 32'(v.left));
    check($sformatf("v%0d screens", idx), 32'({start_screen, death_screen, victory_screen}), 32'(v.scr));
    check($sformatf("v%0d pause/newLevel/requestTime", idx), 32'({pause, newLevel, requestTime}), 32'(v.misc));
    check($sformatf("v%0d slowClkRequest", idx), 32'(slowClkRequest), v.misc[0] ? 120 : 0);
    check($sformatf("v%0d curEnemySpeed", idx), 32'(curEnemySpeed), 32'(120 + 60 * int'(v.lvl)));
    check($sformatf("v%0d tree_count", idx), 32'(tree_count), 32'(8 + int'(v.lvl)));
  endtask

  initial begin
    //   rst life coll  sclk trig | st  lvl left scr     misc
    add(0, 3, 3'b000, 0, 0,  0, 0, 2, 3'b100, 3'b100); // reset
    add(1, 3, 3'b000, 0, 1,  1, 0, 2, 3'b000, 3'b000); // trigger edge -> PLAY
    add(1, 3, 3'b000, 0, 1,  1, 0, 2, 3'b000, 3'b000); // held trigger
    add(1, 3, 3'b011, 0, 0,  2, 0, 0, 3'b000, 3'b101); // 2 kills -> LEVEL_DONE
    add(1, 3, 3'b000, 1, 0,  2, 0, 0, 3'b000, 3'b110); // slowClk ignored in LEVEL_DONE
    add(1, 3, 3'b000, 0, 0,  2, 0, 0, 3'b000, 3'b110); // wait in TRANSITION
    add(1, 3, 3'b000, 1, 0,  1, 1, 3, 3'b000, 3'b000); // slowClk -> level 1
    add(1, 3, 3'b001, 0, 0,  1, 1, 2, 3'b000, 3'b000); // one kill
    add(1, 3, 3'b001, 0, 0,  1, 1, 2, 3'b000, 3'b000); // held hit not recounted
    add(1, 3, 3'b001, 0, 0,  1, 1, 2, 3'b000, 3'b000);
    add(1, 3, 3'b000, 0, 0,  1, 1, 2, 3'b000, 3'b000);
    add(1, 0, 3'b101, 0, 0,  2, 1, 0, 3'b000, 3'b101); // clear beats death
    add(1, 3, 3'b000, 0, 0,  2, 1, 0, 3'b000, 3'b110);
    add(1, 3, 3'b000, 1, 0,  1, 2, 4, 3'b000, 3'b000); // level 2 needs 4
    add(1, 3, 3'b111, 0, 0,  1, 2, 1, 3'b000, 3'b000);
    add(1, 0, 3'b000, 0, 0,  5, 2, 1, 3'b010, 3'b100); // death
    add(1, 3, 3'b000, 0, 1,  0, 0, 2, 3'b100, 3'b100); // trigger -> START
    add(1, 3, 3'b000, 0, 1,  0, 0, 2, 3'b100, 3'b100); // held: no second advance
    add(1, 3, 3'b000, 0, 0,  0, 0, 2, 3'b100, 3'b100);
    add(1, 3, 3'b000, 0, 1,  1, 0, 2, 3'b000, 3'b000);
    add(1, 3, 3'b011, 0, 0,  2, 0, 0, 3'b000, 3'b101);
    add(1, 3, 3'b000, 0, 0,  2, 0, 0, 3'b000, 3'b110);
    add(1, 3, 3'b000, 1, 0,  1, 1, 3, 3'b000, 3'b000);
    add(1, 3, 3'b111, 0, 0,  2, 1, 0, 3'b000, 3'b101);
    add(1, 3, 3'b000, 0, 0,  2, 1, 0, 3'b000, 3'b110);
    add(1, 3, 3'b000, 1, 0,  1, 2, 4, 3'b000, 3'b000);
    add(1, 3, 3'b111, 0, 0,  1, 2, 1, 3'b000, 3'b000);
    add(1, 3, 3'b000, 0, 0,  1, 2, 1, 3'b000, 3'b000);
    add(1, 3, 3'b111, 0, 0,  2, 2, 0, 3'b000, 3'b101); // 3 kills vs 1 left saturates
    add(1, 3, 3'b000, 0, 0,  2, 2, 0, 3'b000, 3'b110);
    add(1, 3, 3'b000, 1, 0,  1, 3, 5, 3'b000, 3'b000); // last level needs 5
    add(1, 3, 3'b111, 0, 0,  1, 3, 2, 3'b000, 3'b000);
    add(1, 3, 3'b000, 0, 0,  1, 3, 2, 3'b000, 3'b000);
    add(1, 3, 3'b011, 0, 0,  2, 3, 0, 3'b000, 3'b101);
    add(1, 3, 3'b000, 1, 0,  4, 3, 0, 3'b001, 3'b100); // VICTORY, no TRANSITION
    add(1, 3, 3'b000, 0, 1,  1, 0, 2, 3'b000, 3'b000); // replay from level 0
    add(1, 3, 3'b000, 0, 0,  1, 0, 2, 3'b000, 3'b000);

    @(negedge clk);
    foreach (vecs[i]) begin
      resetN             = vecs[i].rst;
      currLife           = vecs[i].life;
      shotEnemyCollision = vecs[i].coll;
      slowClk            = vecs[i].sclk;
      playerTrigger      = vecs[i].trig;
      @(negedge clk);
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a transition.
    shotEnemyCollision = 3'b011;
    @(negedge clk);
    check("seq level_done", 32'(requestTime), 1);
    shotEnemyCollision = 3'b000;
    @(negedge clk);
    check("seq transition newLevel", 32'(newLevel), 1);
    #2 resetN = 1'b0;
    #1;
    check("async reset state", 32'(currentGameState), 0);
    check("async reset newLevel", 32'(newLevel), 0);
    check("async reset level", 32'(level), 0);
    check("async reset start_screen", 32'(start_screen), 1);
    check("async reset enemies_left", 32'(enemies_left), 2);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("post reset stays START", 32'(currentGameState), 0);

`ifdef GAME_SEQ_PAUSE_EN
    playerTrigger = 1'b1;
    @(negedge clk);
    playerTrigger = 1'b0;
    check("pause seq PLAY", 32'(currentGameState), 1);
    playerPause = 1'b1;
    @(negedge clk);
    playerPause = 1'b0;
    check("paused state", 32'(currentGameState), 6);
    check("paused pause", 32'(pause), 1);
    shotEnemyCollision = 3'b011;
    currLife = 3'd0;
    @(negedge clk);
    check("paused ignores hits/death", 32'(currentGameState), 6);
    check("paused enemies_left", 32'(enemies_left), 2);
    shotEnemyCollision = 3'b000;
    currLife = 3'd3;
    playerPause = 1'b1;
    @(negedge clk);
    playerPause = 1'b0;
    check("unpause state", 32'(currentGameState), 1);
    check("unpause enemies_left", 32'(enemies_left), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
